// File: rtl/fn_recfn_convert_pipe.sv
// Registered two-way converter between IEEE binary floats (FN) and the recoded recFN format.
// Optional build macro FN_RECFN_CANON_NAN_EN: the decode path emits the canonical quiet NaN.
module fn_recfn_convert_pipe #(
    parameter int exp_width_p = 8,
    parameter int sig_width_p = 24
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 fn_v_i,
    input  logic [exp_width_p+sig_width_p-1:0]   fn_i,
    output logic                                 rec_v_o,
    output logic [exp_width_p+sig_width_p:0]     rec_o,
    input  logic                                 rec_v_i,
    input  logic [exp_width_p+sig_width_p:0]     rec_i,
    output logic                                 fn_v_o,
    output logic [exp_width_p+sig_width_p-1:0]   fn_o
);

    localparam int e_w  = exp_width_p;
    localparam int s_w  = sig_width_p;
    localparam int fw   = s_w - 1;
    localparam int fn_w = e_w + s_w;
    localparam int rw   = e_w + s_w + 1;
    localparam int bias = 1 << (e_w - 1);

    localparam logic [e_w:0] rec_b1 = (e_w + 1)'(bias + 1);
    localparam logic [e_w:0] rec_b2 = (e_w + 1)'(bias + 2);

    // ---------------- FN -> recFN ----------------
    logic              fn_sign;
    logic [e_w-1:0]    fn_exp;
    logic [fw-1:0]     fn_fract;
    logic              fract_nz;
    logic [e_w:0]      lz;
    logic [e_w:0]      rec_exp_next;
    logic [fw-1:0]     rec_fract_next;

    assign fn_sign  = fn_i[fn_w-1];
    assign fn_exp   = fn_i[fn_w-2 -: e_w];
    assign fn_fract = fn_i[fw-1:0];
    assign fract_nz = |fn_fract;

    // Leading-zero count of the fraction; the highest set bit wins.
    always_comb begin
        lz = '0;
        for (int i = 0; i < fw; i++) begin
            if (fn_fract[i]) lz = (e_w + 1)'(fw - 1 - i);
        end
    end

    always_comb begin
        rec_exp_next   = '0;
        rec_fract_next = fn_fract;
        if (fn_exp == '0) begin
            if (fract_nz) begin
                // Normalise: drop the leading one into the implicit position.
                rec_exp_next   = rec_b1 - lz;
                rec_fract_next = fn_fract << (lz + 1'b1);
            end
        end else if (&fn_exp) begin
            rec_exp_next = {2'b11, fract_nz, {(e_w - 2){1'b0}}};
        end else begin
            rec_exp_next = {1'b0, fn_exp} + rec_b1;
        end
    end

    // ---------------- recFN -> FN ----------------
    logic              r_sign;
    logic [e_w:0]      r_exp;
    logic [fw-1:0]     r_fract;
    logic [e_w:0]      sub_shift;
    logic              fn_sign_next;
    logic [e_w-1:0]    fn_exp_next;
    logic [fw-1:0]     fn_fract_next;

    assign r_sign    = rec_i[rw-1];
    assign r_exp     = rec_i[rw-2 -: e_w + 1];
    assign r_fract   = rec_i[fw-1:0];
    assign sub_shift = rec_b2 - r_exp;

    always_comb begin
        fn_sign_next  = r_sign;
        fn_exp_next   = '0;
        fn_fract_next = '0;
        if (r_exp[e_w:e_w-2] == 3'b000) begin
            fn_exp_next = '0;
        end else if (r_exp[e_w:e_w-1] == 2'b11) begin
            fn_exp_next = '1;
            if (r_exp[e_w-2]) begin
`ifdef FN_RECFN_CANON_NAN_EN
                fn_sign_next  = 1'b0;
                fn_fract_next = {1'b1, {(fw - 1){1'b0}}};
`else
                fn_fract_next = r_fract;
`endif
            end
        end else if (r_exp < rec_b2) begin
            // Denormalise: restore the hidden one and shift it back into the fraction.
            fn_fract_next = fw'({1'b1, r_fract} >> sub_shift);
        end else begin
            fn_exp_next   = r_exp[e_w-1:0] - rec_b1[e_w-1:0];
            fn_fract_next = r_fract;
        end
    end

    // ---------------- output registers ----------------
    logic              rec_v_reg;
    logic [rw-1:0]     rec_reg;
    logic              fn_v_reg;
    logic [fn_w-1:0]   fn_reg;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rec_v_reg <= 1'b0;
            rec_reg   <= '0;
            fn_v_reg  <= 1'b0;
            fn_reg    <= '0;
        end else begin
            rec_v_reg <= fn_v_i;
            fn_v_reg  <= rec_v_i;
            if (fn_v_i) rec_reg <= {fn_sign, rec_exp_next, rec_fract_next};
            if (rec_v_i) fn_reg <= {fn_sign_next, fn_exp_next, fn_fract_next};
        end
    end

    assign rec_v_o = rec_v_reg;
    assign rec_o   = rec_reg;
    assign fn_v_o  = fn_v_reg;
    assign fn_o    = fn_reg;

endmodule

// File: tb/tb_fn_recfn_convert_pipe.sv
// Scoreboard bench for fn_recfn_convert_pipe (E=8, S=24): directed vectors plus random round trips.
module tb_fn_recfn_convert_pipe;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        fn_v_i = 1'b0;
    logic [31:0] fn_i = '0;
    logic        rec_v_o;
    logic [32:0] rec_o;
    logic        rec_v_i = 1'b0;
    logic [32:0] rec_i = '0;
    logic        fn_v_o;
    logic [31:0] fn_o;

    fn_recfn_convert_pipe #(.exp_width_p(8), .sig_width_p(24)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .fn_v_i  (fn_v_i),
        .fn_i    (fn_i),
        .rec_v_o (rec_v_o),
        .rec_o   (rec_o),
        .rec_v_i (rec_v_i),
        .rec_i   (rec_i),
        .fn_v_o  (fn_v_o),
        .fn_o    (fn_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        chk;
        logic [32:0] val;
    } rec_exp_t;

    rec_exp_t    rec_q[$];
    logic [31:0] fn_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [31:0] back_of(input logic [31:0] v);
`ifdef FN_RECFN_CANON_NAN_EN
        if ((&v[30:23]) && (|v[22:0])) return 32'h7fc00000;
`endif
        return v;
    endfunction

    task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: pops expectations whenever an output is valid.
    always @(negedge clk) begin
        if (!reset_i) begin
            if (rec_v_o) begin
                if (rec_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rec_unexpected: got %h expected no output", rec_o);
                end else begin
                    rec_exp_t e;
                    e = rec_q.pop_front();
                    if (e.chk) begin
                        n_cmp++;
                        if (rec_o !== e.val) begin
                            n_bad++;
                            $display("FAIL rec_o: got %h expected %h", rec_o, e.val);
                        end
                    end
                end
            end
            if (fn_v_o) begin
                if (fn_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL fn_unexpected: got %h expected no output", fn_o);
                end else begin
                    logic [31:0] ef;
                    ef = fn_q.pop_front();
                    n_cmp++;
                    if (fn_o !== ef) begin
                        n_bad++;
                        $display("FAIL fn_o: got %h expected %h", fn_o, ef);
                    end
                end
            end
        end
    end

    // One clock of stimulus on either or both paths; called at posedge+1.
    task automatic issue(input logic fv, input logic [31:0] f, input logic [32:0] er,
                         input logic rv, input logic [32:0] r, input logic [31:0] ef);
        fn_v_i  = fv;
        fn_i    = f;
        rec_v_i = rv;
        rec_i   = r;
        if (fv) rec_q.push_back({1'b1, er});
        if (rv) fn_q.push_back(ef);
        @(posedge clk);
        #1;
        $display("issue fn_v=%0b fn=%h rec_v=%0b rec=%h", fv, f, rv, r);
        fn_v_i  = 1'b0;
        rec_v_i = 1'b0;
    endtask

    localparam int NV = 10;
    logic [31:0] fn_vec  [NV] = '{32'h7fc00000, 32'h3f800000, 32'h00000000, 32'h00000001,
                                  32'h00400000, 32'h80800000, 32'hff800000, 32'hffc12345,
                                  32'h7f7fffff, 32'h80000000};
    logic [32:0] rec_vec [NV] = '{33'h0e0400000, 33'h080000000, 33'h000000000, 33'h035800000,
                                  33'h040800000, 33'h141000000, 33'h1c0000000, 33'h1e0412345,
                                  33'h0bfffffff, 33'h100000000};

    initial begin
        logic        prev_v;
        logic [31:0] prev_val;
        logic [31:0] r;
        logic [32:0] held;

        // Reset state
        #2;
        check("reset_rec_v", {32'h0, rec_v_o}, 33'h0);
        check("reset_rec_o", rec_o, 33'h0);
        check("reset_fn_v", {32'h0, fn_v_o}, 33'h0);
        check("reset_fn_o", {1'b0, fn_o}, 33'h0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;

        // Directed: encode and decode the same vector simultaneously, with gaps.
        for (int i = 0; i < NV; i++) begin
            issue(1'b1, fn_vec[i], rec_vec[i], 1'b1, rec_vec[i], back_of(fn_vec[i]));
            if (i % 3 == 2) begin
                @(posedge clk);
                #1;
            end
        end

        // Outputs hold their last value while inputs are idle.
        held = rec_vec[NV-1];
        repeat (2) @(posedge clk);
        #1;
        check("hold_rec_o", rec_o, held);
        check("hold_fn_o", {1'b0, fn_o}, {1'b0, back_of(fn_vec[NV-1])});

        // Asynchronous reset in the middle of traffic.
        issue(1'b1, 32'h3f800000, 33'h080000000, 1'b1, 33'h0bfffffff, 32'h7f7fffff);
        #2;
        reset_i = 1'b1;
        #1;
        check("midreset_rec_v", {32'h0, rec_v_o}, 33'h0);
        check("midreset_rec_o", rec_o, 33'h0);
        check("midreset_fn_v", {32'h0, fn_v_o}, 33'h0);
        check("midreset_fn_o", {1'b0, fn_o}, 33'h0);
        rec_q.delete();
        fn_q.delete();
        #3;
        reset_i = 1'b0;
        @(posedge clk);
        #1;

        // Random round trips: encode path feeds the decode path one cycle later.
        prev_v   = 1'b0;
        prev_val = '0;
        for (int k = 0; k < 10000; k++) begin
            rec_v_i = prev_v;
            rec_i   = rec_o;
            if (prev_v) fn_q.push_back(back_of(prev_val));
            r = $urandom;
            case ($urandom_range(0, 7))
                0: r[30:23] = 8'h00;
                1: r[30:23] = 8'hff;
                2: r[30:0]  = '0;
                default: ;
            endcase
            fn_v_i = ($urandom_range(0, 3) != 0);
            fn_i   = r;
            if (fn_v_i) rec_q.push_back({1'b0, 33'h0});
            prev_v   = fn_v_i;
            prev_val = r;
            @(posedge clk);
            #1;
        end
        rec_v_i = prev_v;
        rec_i   = rec_o;
        if (prev_v) fn_q.push_back(back_of(prev_val));
        fn_v_i = 1'b0;
        @(posedge clk);
        #1;
        rec_v_i = 1'b0;

        // Bounded drain of outstanding expectations.
        for (int w = 0; w < 20 && (rec_q.size() != 0 || fn_q.size() != 0); w++) begin
            @(posedge clk);
            #1;
        end
        if (rec_q.size() != 0 || fn_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", rec_q.size(), fn_q.size());
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
